alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
Bit-serial sequencer that runs a 1-bit ALU slice over a WIDTH-bit operand pair, LSB first, one bit per clock.
- Latches operands and opcode on a start handshake.
- Threads the carry through a flop between bit steps.
- Assembles the result in a shift register and reports result, carry and zero flags with a done pulse.
- Area-minimal ALU option for the CPU; its opcode encoding is identical to the rest of the ALU.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin an operation; sampled only in IDLE.
opcode  input  4  operation code, captured with start.
a  input  WIDTH  operand A, captured with start.
b  input  WIDTH  operand B, captured with start.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse; result, carry and zero are valid from this cycle.
result  output  WIDTH  registered result, held until the next done.
carry  output  1  registered final carry-out.
zero  output  1  registered flag, 1 when result == 0.

Behaviour:
- Reset (rst=1 at a clock edge, from any state):
  - state=IDLE, busy=0, done=0, result=0, carry=0, zero=0.
  - Shift registers and bit counter cleared.
  - An in-flight operation is discarded and produces no done.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOR, 0101 XOR, 0110 XNOR, 0111 NAND.
  - 1000 PASS_A, 1001 PASS_B, 1010 ZERO.
  - 1011 and 1100 are compare forms: they run the SUB carry chain, result bits are 0, carry is meaningful.
  - 1101-1111: result 0, carry 0.
- B inversion and initial carry: B is inverted and the initial carry is 1 for 0001, 1011 and 1100; otherwise the initial carry is 0.
- Carry chain: each step computes sum = a_i ^ b'_i ^ c and cout = a_i&b'_i | c&(a_i^b'_i). The carry flop takes cout every RUN cycle for all opcodes.
- Carry output:
  - ADD, SUB, 1011, 1100: final cout of bit WIDTH-1 (for SUB forms, 1 means no borrow).
  - All other opcodes: 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: busy=0. start=1 latches opcode, a, b, initial carry and counter=0, then goes to RUN.
  - RUN: each cycle the slice consumes a_sh[0], b_sh[0] and the carry flop. The result bit shifts into the MSB of the result shift register; a_sh and b_sh shift right; counter increments. When counter==WIDTH-1 the state goes to DONE.
  - DONE: output registers load result, carry and zero; done=1 for exactly this cycle; next state IDLE.
- Latency: start sampled at edge T gives done high in the cycle after edge T+WIDTH. The done cycle begins WIDTH+1 cycles after start is sampled. The earliest next accepted start is the cycle after done.
- start in RUN or DONE is ignored and its operands are not captured. Inputs are don't-care except in an IDLE cycle with start=1.
- Outputs result, carry and zero change only in the DONE transition or on reset, never mid-RUN.
- Counter width is $clog2(WIDTH), and the counter does not wrap within an operation.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode localparams (OP_ADD ... OP_ZERO, OP_CMP0=1011, OP_CMP1=1100).
  - A helper function is_sub(opcode) that returns 1 for 0001/1011/1100.
  - The FSM state enum {IDLE, RUN, DONE}.
- One sub-module, alu_bit_slice: combinational 1-bit slice with inputs opcode, a, b, cin and outputs result, cout. It is instantiated once.
- The FSM, shift registers and flags live in alu_serial_seq.

Test Plan:
1. WIDTH=8, ADD a=0x0F b=0x01 -> result 0x10, carry 0, zero 0; done exactly 9 cycles after start sampled; busy high for those 9 cycles.
2. ADD a=0xFF b=0x01 -> result 0x00, carry 1, zero 1. SUB a=0x05 b=0x05 -> 0x00, carry 1, zero 1. SUB a=0x03 b=0x05 -> 0xFE, carry 0, zero 0.
3. NAND a=0xF0 b=0xCC -> 0x3F, carry 0. PASS_B b=0xA5 -> 0xA5. CMP 1011 a=0x02 b=0x01 -> result 0x00, carry 1, zero 1. Opcode 1111 -> 0x00, carry 0.
4. ADD 0x01+0x01 started, then start with SUB 0x10,0x01 pulsed mid-RUN -> ignored; done reports 0x02. A start in the cycle after done is accepted and returns 0x0F.
5. rst asserted on the 4th RUN cycle of ADD 0x0F+0x01 -> next cycle busy 0, done 0, result 0, no done pulse. A following ADD 0x20+0x03 completes with 0x23.
6. Output hold: after done with 0x10, operand and opcode inputs toggle for 20 cycles with start=0 -> result, carry and zero unchanged; done stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, sequencer states, opcode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_NOR    = 4'b0100;
    localparam logic [3:0] OP_XOR    = 4'b0101;
    localparam logic [3:0] OP_XNOR   = 4'b0110;
    localparam logic [3:0] OP_NAND   = 4'b0111;
    localparam logic [3:0] OP_PASS_A = 4'b1000;
    localparam logic [3:0] OP_PASS_B = 4'b1001;
    localparam logic [3:0] OP_ZERO   = 4'b1010;
    localparam logic [3:0] OP_CMP0   = 4'b1011;
    localparam logic [3:0] OP_CMP1   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes that run the subtract chain: B inverted, carry-in of 1.
    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_CMP0) || (op == OP_CMP1);
    endfunction

    // Opcodes whose final carry-out is reported; all others report 0.
    function automatic logic keeps_carry(input logic [3:0] op);
        return (op == OP_ADD) || is_sub(op);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: one bit of result plus the carry to the next bit.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       result,
    output logic       cout
);

    logic b_eff;
    logic sum;

    // Carry chain is always evaluated; the sequencer decides whether its carry is reported.
    assign b_eff = b ^ is_sub(opcode);
    assign sum   = a ^ b_eff ^ cin;
    assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

    // Per-opcode result bit; logic ops use the raw B, compares produce no result bits.
    always_comb begin
        result = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: result = sum;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_NOR:         result = ~(a | b);
            OP_XOR:         result = a ^ b;
            OP_XNOR:        result = ~(a ^ b);
            OP_NAND:        result = ~(a & b);
            OP_PASS_A:      result = a;
            OP_PASS_B:      result = b;
            default:        result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one slice, LSB first, one bit per clock, flags on done.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    // Holds the upper WIDTH-1 bits assembled so far; the newest bit joins at the MSB.
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             bit_res;
    logic             bit_cout;

    alu_bit_slice u_slice (
        .opcode (op_q),
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (c_q),
        .result (bit_res),
        .cout   (bit_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign r_nxt    = {bit_res, r_sh};
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE waits for start, RUN counts WIDTH bits, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on start, shift per bit, publish outputs on the edge entering DONE
    // so they are already valid in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        a_sh <= a;
                        b_sh <= b;
                        c_q  <= is_sub(opcode);
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nxt[WIDTH-1:1];
                    c_q  <= bit_cout;
                    if (last_bit) begin
                        result <= r_nxt;
                        carry  <= keeps_carry(op_q) & bit_cout;
                        zero   <= (r_nxt == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=8).
module tb_alu_serial_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, carry, zero;
    logic [WIDTH-1:0] result;

    int n_chk = 0;
    int n_err = 0;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    // Returns at the negedge of the first cycle after that edge (cycle 1).
    task automatic start_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        start  = 1'b1;
        opcode = op;
        a      = va;
        b      = vb;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts cycles after start was sampled (the first cycle after the edge is 1) until
    // done is seen; busy is expected in every one of those cycles.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] er, input logic ec,
                          input logic ez);
        int cyc, bc;
        start_op(op, va, vb);
        wait_done(cyc, bc);
        chk({tag, "_lat"},   32'(cyc),    32'(WIDTH + 1));
        chk({tag, "_busy"},  32'(bc),     32'(WIDTH + 1));
        chk({tag, "_res"},   32'(result), 32'(er));
        chk({tag, "_carry"}, 32'(carry),  32'(ec));
        chk({tag, "_zero"},  32'(zero),   32'(ez));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done),   32'd0);
    endtask

    initial begin
        int cyc, bc, seen;
        rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry",  32'(carry),  32'd0);
        chk("rst_zero",   32'(zero),   32'd0);

        // Arithmetic
        run_op("add_0f_01",  4'b0000, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        run_op("add_ff_01",  4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("sub_05_05",  4'b0001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        run_op("sub_03_05",  4'b0001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        // Logic and moves; carry forced to 0 even when the chain would carry
        run_op("nand",       4'b0111, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0);
        run_op("and_ff",     4'b0010, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op("or",         4'b0011, 8'h0C, 8'h30, 8'h3C, 1'b0, 1'b0);
        run_op("nor",        4'b0100, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0);
        run_op("xor",        4'b0101, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0);
        run_op("xnor",       4'b0110, 8'hAA, 8'h0F, 8'h5A, 1'b0, 1'b0);
        run_op("pass_a",     4'b1000, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0);
        run_op("pass_b",     4'b1001, 8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_op("zero_op",    4'b1010, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        // Compares: no result bits, subtract carry (1 = no borrow)
        run_op("cmp0_02_01", 4'b1011, 8'h02, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("cmp1_01_02", 4'b1100, 8'h01, 8'h02, 8'h00, 1'b0, 1'b1);
        run_op("op_1111",    4'b1111, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);

        // start during RUN is ignored; a start in the cycle after done is accepted
        start_op(4'b0000, 8'h01, 8'h01);
        @(negedge clk);
        start = 1'b1; opcode = 4'b0001; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        chk("ign_lat",   32'(cyc),    32'(WIDTH - 1));
        chk("ign_res",   32'(result), 32'h02);
        chk("ign_carry", 32'(carry),  32'd0);
        @(negedge clk);
        chk("ign_busy_after", 32'(busy), 32'd0);
        run_op("b2b_or", 4'b0011, 8'h0C, 8'h03, 8'h0F, 1'b0, 1'b0);

        // Reset in the 4th RUN cycle discards the operation
        start_op(4'b0000, 8'h0F, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy",   32'(busy),   32'd0);
        chk("mid_rst_done",   32'(done),   32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        run_op("post_rst_add", 4'b0000, 8'h20, 8'h03, 8'h23, 1'b0, 1'b0);

        // Output hold while inputs toggle with start low
        run_op("hold_add", 4'b0000, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            opcode = 4'(i);
            a      = 8'(i * 37);
            b      = ~8'(i * 11);
            @(negedge clk);
            if (done) seen++;
            chk("hold_res",   32'(result), 32'h10);
            chk("hold_carry", 32'(carry),  32'd0);
            chk("hold_zero",  32'(zero),   32'd0);
        end
        chk("hold_no_done", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
